demux1_4_stream: RTL and testbench

- 16-bit, 1-to-4 stream demultiplexer. It is the distributing counterpart of the team's 4:1 data mux.
- Accepts one word per valid/ready handshake and routes it to one of four registered output channels.
- The channel is chosen by an explicit selector, or by a round-robin pointer when rr_mode is set.
- Sits between a single producer and four consumer lanes, and counts completed deliveries per lane.

---
 rtl/demux1_4_stream_if.sv | 29 ++
 rtl/demux1_4_stream.sv | 77 +++++++
 tb/tb_demux1_4_stream.sv | 135 +++++++++++++
 3 files changed

// File: rtl/demux1_4_stream_if.sv
// Stream bundle for the 1-to-4 demux: producer side, four consumer lanes, per-lane counters.
// Latency: none (signal bundle only).
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface demux1_4_stream_if #(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 8
);
   logic [WIDTH-1:0]     in_data;
   logic [1:0]           in_sel;
   logic                 in_valid;
   logic                 in_ready;
   logic                 rr_mode;
   logic [4*WIDTH-1:0]   out_data;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [4*COUNT_W-1:0] xfer_cnt;

   // Producer/consumer environment side.
   modport master (
      output in_data, in_sel, in_valid, rr_mode, out_ready,
      input  in_ready, out_data, out_valid, xfer_cnt
   );

   // Demux side.
   modport slave (
      input  in_data, in_sel, in_valid, rr_mode, out_ready,
      output in_ready, out_data, out_valid, xfer_cnt
   );
endinterface

// File: rtl/demux1_4_stream.sv
// 1-to-4 stream demux: routes each accepted word to one of four one-entry lane registers and counts pops per lane.
// Latency: exactly one cycle from accept to out_valid on the destination lane.
// Backpressure: in_ready drops while the destination lane is full and not popping; later words never bypass a stalled one.
module demux1_4_stream #(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   demux1_4_stream_if.slave s
);

   logic [WIDTH-1:0]     data_q [4];
   logic [3:0]           valid_q;
   logic [COUNT_W-1:0]   cnt_q  [4];
   logic [1:0]           rr_ptr;

   logic [1:0]           dest;
   logic [3:0]           free;
   logic [3:0]           pop;
   logic                 ready_c;
   logic                 accept;
   logic [4*WIDTH-1:0]   data_flat;
   logic [4*COUNT_W-1:0] cnt_flat;

   // Destination select and handshake; a lane popping this cycle can be refilled in the same edge.
   always_comb begin
      pop     = valid_q & s.out_ready;
      free    = ~valid_q | s.out_ready;
      dest    = s.rr_mode ? rr_ptr : s.in_sel;
      ready_c = rst_n && free[dest];
      accept  = s.in_valid && ready_c;
   end

   // Lane registers, delivery counters and round-robin pointer; reset discards pending words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         rr_ptr  <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && dest == 2'(i)) begin
               valid_q[i] <= 1'b1;
               data_q[i]  <= s.in_data;
            end else if (pop[i]) begin
               valid_q[i] <= 1'b0;
            end
            if (pop[i]) begin
               cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
            end
         end
         if (accept && s.rr_mode) begin
            rr_ptr <= rr_ptr + 2'd1;
         end
      end
   end

   // Flatten lane storage onto the packed output buses.
   always_comb begin
      data_flat = '0;
      cnt_flat  = '0;
      for (int i = 0; i < 4; i++) begin
         data_flat[i*WIDTH +: WIDTH]     = data_q[i];
         cnt_flat[i*COUNT_W +: COUNT_W]  = cnt_q[i];
      end
   end

   assign s.in_ready  = ready_c;
   assign s.out_valid = valid_q;
   assign s.out_data  = data_flat;
   assign s.xfer_cnt  = cnt_flat;

endmodule

// File: tb/tb_demux1_4_stream.sv
// Directed bench for demux1_4_stream: vector table plus hand-written wrap and mid-run reset sequences.
// Latency: inputs driven on the falling edge, registered outputs sampled 1 ns after the rising edge.
// Backpressure: out_ready patterns are part of each vector.
`timescale 1ns/1ps
module tb_demux1_4_stream;
   localparam int WIDTH   = 16;
   localparam int COUNT_W = 8;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [1:0]  sel;
      logic        rr;
      logic [15:0] dat;
      logic [3:0]  ordy;
      logic        erdy;
      logic [3:0]  eov;
      logic [63:0] eod;
      logic [31:0] ecnt;
   } vec_t;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;
   vec_t vecs[$];

   demux1_4_stream_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

   demux1_4_stream #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic rst, logic vld, logic [1:0] sel, logic rr, logic [15:0] dat,
                               logic [3:0] ordy, logic erdy, logic [3:0] eov, logic [63:0] eod,
                               logic [31:0] ecnt);
      vec_t v;
      v.rst = rst; v.vld = vld; v.sel = sel; v.rr = rr; v.dat = dat; v.ordy = ordy;
      v.erdy = erdy; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
   endtask

   // One cycle: drive on the falling edge, check in_ready before the rising edge, registered state after it.
   task automatic step(input vec_t v, input int idx);
      @(negedge clk);
      rst_n         = v.rst;
      bus.in_valid  = v.vld;
      bus.in_sel    = v.sel;
      bus.rr_mode   = v.rr;
      bus.in_data   = v.dat;
      bus.out_ready = v.ordy;
      #1;
      chk("in_ready", idx, 64'(bus.in_ready), 64'(v.erdy));
      @(posedge clk);
      #1;
      chk("out_valid", idx, 64'(bus.out_valid), 64'(v.eov));
      chk("out_data", idx, bus.out_data, v.eod);
      chk("xfer_cnt", idx, 64'(bus.xfer_cnt), 64'(v.ecnt));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'd0;
      bus.rr_mode   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 4'hF;

      //                rst vld sel  rr  dat        ordy     rdy  eov      eod                       ecnt
      vecs.push_back(mk(0, 1, 2'd0, 0, 16'hFFFF, 4'b1111, 0, 4'b0000, 64'h0000_0000_0000_0000, 32'h00000000));
      vecs.push_back(mk(0, 1, 2'd0, 0, 16'hFFFF, 4'b1111, 0, 4'b0000, 64'h0000_0000_0000_0000, 32'h00000000));
      vecs.push_back(mk(1, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'h0000_0000_0000_0000, 32'h00000000));
      // selector routing
      vecs.push_back(mk(1, 1, 2'd0, 0, 16'hA001, 4'b1111, 1, 4'b0001, 64'h0000_0000_0000_A001, 32'h00000000));
      vecs.push_back(mk(1, 1, 2'd1, 0, 16'hB002, 4'b1111, 1, 4'b0010, 64'h0000_0000_B002_A001, 32'h00000001));
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'hC003, 4'b1111, 1, 4'b0100, 64'h0000_C003_B002_A001, 32'h00000101));
      vecs.push_back(mk(1, 1, 2'd3, 0, 16'hD004, 4'b1111, 1, 4'b1000, 64'hD004_C003_B002_A001, 32'h00010101));
      vecs.push_back(mk(1, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'hD004_C003_B002_A001, 32'h01010101));
      // backpressure on lane 2, pop+refill in one edge, no bypass
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'h1234, 4'b1011, 1, 4'b0100, 64'hD004_1234_B002_A001, 32'h01010101));
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'h5678, 4'b1011, 0, 4'b0100, 64'hD004_1234_B002_A001, 32'h01010101));
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'h5678, 4'b1111, 1, 4'b0100, 64'hD004_5678_B002_A001, 32'h01020101));
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'h9ABC, 4'b1011, 0, 4'b0100, 64'hD004_5678_B002_A001, 32'h01020101));
      vecs.push_back(mk(1, 1, 2'd2, 0, 16'h9ABC, 4'b1111, 1, 4'b0100, 64'hD004_9ABC_B002_A001, 32'h01030101));
      vecs.push_back(mk(1, 1, 2'd1, 0, 16'h4321, 4'b1111, 1, 4'b0010, 64'hD004_9ABC_4321_A001, 32'h01040101));
      vecs.push_back(mk(1, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'hD004_9ABC_4321_A001, 32'h01040201));
      // round robin with wrap, then mode switch mid-stream
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0000, 4'b1111, 1, 4'b0001, 64'hD004_9ABC_4321_0000, 32'h01040201));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0001, 4'b1111, 1, 4'b0010, 64'hD004_9ABC_0001_0000, 32'h01040202));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0002, 4'b1111, 1, 4'b0100, 64'hD004_0002_0001_0000, 32'h01040302));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0003, 4'b1111, 1, 4'b1000, 64'h0003_0002_0001_0000, 32'h01050302));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0004, 4'b1111, 1, 4'b0001, 64'h0003_0002_0001_0004, 32'h02050302));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0005, 4'b1111, 1, 4'b0010, 64'h0003_0002_0005_0004, 32'h02050303));
      vecs.push_back(mk(1, 1, 2'd0, 0, 16'h0A0A, 4'b1111, 1, 4'b0001, 64'h0003_0002_0005_0A0A, 32'h02050403));
      vecs.push_back(mk(1, 1, 2'd0, 1, 16'h0B0B, 4'b1111, 1, 4'b0100, 64'h0003_0B0B_0005_0A0A, 32'h02050404));
      vecs.push_back(mk(1, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'h0003_0B0B_0005_0A0A, 32'h02060404));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Lane 3 counter wrap: 256 back-to-back words, each popped one cycle later.
      for (int k = 0; k < 256; k++) begin
         logic [7:0] c3;
         c3 = 8'(2 + k);
         step(mk(1, 1, 2'd3, 0, 16'(k), 4'b1111, 1, 4'b1000,
                 {16'(k), 48'h0B0B_0005_0A0A}, {c3, 24'h060404}), 100 + k);
      end
      step(mk(1, 0, 2'd3, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'h00FF_0B0B_0005_0A0A, 32'h02060404), 400);

      // Reset mid-operation with lanes 0,1,3 loaded and rr_ptr at 3.
      step(mk(1, 1, 2'd0, 0, 16'h1111, 4'b0000, 1, 4'b0001, 64'h00FF_0B0B_0005_1111, 32'h02060404), 500);
      step(mk(1, 1, 2'd1, 0, 16'h2222, 4'b0000, 1, 4'b0011, 64'h00FF_0B0B_2222_1111, 32'h02060404), 501);
      step(mk(1, 1, 2'd3, 0, 16'h3333, 4'b0000, 1, 4'b1011, 64'h3333_0B0B_2222_1111, 32'h02060404), 502);
      step(mk(0, 1, 2'd2, 0, 16'h4444, 4'b0000, 0, 4'b0000, 64'h0000_0000_0000_0000, 32'h00000000), 503);
      step(mk(1, 0, 2'd2, 0, 16'h0000, 4'b1111, 1, 4'b0000, 64'h0000_0000_0000_0000, 32'h00000000), 504);
      step(mk(1, 1, 2'd3, 1, 16'h7777, 4'b0000, 1, 4'b0001, 64'h0000_0000_0000_7777, 32'h00000000), 505);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
